// File: rtl/fp32_to_int32_conv.sv
// FP32 -> signed INT32 converter with start/done handshake and an iterative 1-bit shifter.
// Define FP2INT_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shift.
`timescale 1ns/1ps
module fp32_to_int32_conv #(
  parameter int MAX_RSHIFT = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [1:0]  round_mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] resultInt,
  output logic        errorConv,
  output logic        overflowConv
);

  localparam int CNT_W = $clog2(((MAX_RSHIFT > 7) ? MAX_RSHIFT : 7) + 1);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_SHIFT, S_ROUND} state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [1:0]  r_mode;
  logic [31:0] r_mag;
  logic        r_guard;
  logic        r_sticky;
`ifndef FP2INT_FAST_SHIFT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_left;
`endif

  logic             w_sign;
  logic [7:0]       w_exp;
  logic [22:0]      w_frac;
  logic [23:0]      w_mant;
  logic             w_is_left;
  logic [7:0]       w_rdiff;
  logic [CNT_W-1:0] w_shift_cnt;
  logic [31:0]      w_sat;
  logic             w_inc;
  logic [31:0]      w_mag_rnd;
  logic [31:0]      w_result;

  assign w_sign    = r_a[31];
  assign w_exp     = r_a[30:23];
  assign w_frac    = r_a[22:0];
  assign w_mant    = {1'b1, w_frac};
  // Unbiased exponent >= 23 means the integer part extends past the mantissa LSB.
  assign w_is_left = (w_exp >= 8'd150);
  assign w_rdiff   = 8'd150 - w_exp;
  assign w_sat     = w_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;

  always_comb begin
    w_shift_cnt = '0;
    if (w_is_left)
      w_shift_cnt = CNT_W'(w_exp - 8'd150);
    else if (int'(w_rdiff) > MAX_RSHIFT)
      w_shift_cnt = CNT_W'(MAX_RSHIFT);
    else
      w_shift_cnt = CNT_W'(w_rdiff);
  end

`ifdef FP2INT_FAST_SHIFT_EN
  logic [63:0] w_rext;
  logic [31:0] w_lmag;
  // Mantissa sits above a 32-bit fraction field so guard and sticky fall out of one shift.
  assign w_rext = {8'd0, w_mant, 32'd0} >> w_shift_cnt;
  assign w_lmag = {8'd0, w_mant} << w_shift_cnt;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_inc = 1'b0;
    case (r_mode)
      2'b00:   w_inc = ~w_sign & (r_guard | r_sticky);
      2'b01:   w_inc =  w_sign & (r_guard | r_sticky);
      2'b10:   w_inc = r_guard & (r_sticky | r_mag[0]);
      default: w_inc = r_guard | r_sticky;
    endcase
  end

  assign w_mag_rnd = r_mag + {31'd0, w_inc};
  assign w_result  = w_sign ? (~w_mag_rnd + 32'd1) : w_mag_rnd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_mode       <= '0;
      r_mag        <= '0;
      r_guard      <= 1'b0;
      r_sticky     <= 1'b0;
`ifndef FP2INT_FAST_SHIFT_EN
      r_cnt        <= '0;
      r_left       <= 1'b0;
`endif
      busy         <= 1'b0;
      done         <= 1'b0;
      resultInt    <= '0;
      errorConv    <= 1'b0;
      overflowConv <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_mode  <= round_mode;
            busy    <= 1'b1;
            r_state <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (w_exp == 8'hFF) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
            if (w_frac != '0) begin
              resultInt    <= 32'h8000_0000;
              errorConv    <= 1'b1;
              overflowConv <= 1'b0;
            end else begin
              resultInt    <= w_sat;
              errorConv    <= 1'b0;
              overflowConv <= 1'b1;
            end
          end else if (w_exp >= 8'd158) begin
            done         <= 1'b1;
            busy         <= 1'b0;
            r_state      <= S_IDLE;
            errorConv    <= 1'b0;
            // -2^31 is the only representable value with e >= 31.
            if (r_a == 32'hCF00_0000) begin
              resultInt    <= 32'h8000_0000;
              overflowConv <= 1'b0;
            end else begin
              resultInt    <= w_sat;
              overflowConv <= 1'b1;
            end
          end else if (w_exp == 8'd0) begin
            if (w_frac == '0) begin
              done         <= 1'b1;
              busy         <= 1'b0;
              r_state      <= S_IDLE;
              resultInt    <= '0;
              errorConv    <= 1'b0;
              overflowConv <= 1'b0;
            end else begin
              r_mag    <= '0;
              r_guard  <= 1'b0;
              r_sticky <= 1'b1;
              r_state  <= S_ROUND;
            end
          end else begin
`ifdef FP2INT_FAST_SHIFT_EN
            if (w_is_left) begin
              r_mag    <= w_lmag;
              r_guard  <= 1'b0;
              r_sticky <= 1'b0;
            end else begin
              r_mag    <= w_rext[63:32];
              r_guard  <= w_rext[31];
              r_sticky <= |w_rext[30:0];
            end
            r_state <= S_ROUND;
`else
            r_mag    <= {8'd0, w_mant};
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_left   <= w_is_left;
            r_cnt    <= w_shift_cnt;
            r_state  <= (w_shift_cnt == '0) ? S_ROUND : S_SHIFT;
`endif
          end
        end

`ifndef FP2INT_FAST_SHIFT_EN
        S_SHIFT: begin
          if (r_left) begin
            r_mag <= {r_mag[30:0], 1'b0};
          end else begin
            r_sticky <= r_sticky | r_guard;
            r_guard  <= r_mag[0];
            r_mag    <= {1'b0, r_mag[31:1]};
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= S_ROUND;
        end
`endif

        S_ROUND: begin
          resultInt    <= w_result;
          errorConv    <= 1'b0;
          overflowConv <= 1'b0;
          done         <= 1'b1;
          busy         <= 1'b0;
          r_state      <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
